// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states and parameter defaults.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 16;
    localparam int DEFAULT_FIFO_DEPTH   = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } uart_state_e;

endpackage

// File: rtl/rx_fifo.sv
// Show-ahead receive FIFO; a push into a full FIFO only lands when a pop frees a slot on the same edge.
module rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign empty  = (r_count == '0);
    assign full   = (r_count == CNT_W'(DEPTH));
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);
    // Empty reads as zero so the head is clean after reset and after the last pop.
    assign dout   = empty ? 8'h00 : r_mem[r_rdPtr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling FSM, sticky error flags and a receive FIFO.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rd_en,
    input  logic       clr_err,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       irq
);

    localparam int SCNT_W = $clog2(CLKS_PER_BIT);
    // The IDLE edge that spots the falling line already counts as the first half-bit cycle.
    localparam logic [SCNT_W-1:0] HALF_LAST = SCNT_W'(CLKS_PER_BIT / 2 - 2);
    localparam logic [SCNT_W-1:0] FULL_LAST = SCNT_W'(CLKS_PER_BIT - 1);

    logic              r_rxMeta;
    logic              r_rxSync;
    uart_state_e       r_state;
    uart_state_e       w_stateNext;
    logic [SCNT_W-1:0] r_sampleCnt;
    logic [SCNT_W-1:0] w_sampleNext;
    logic [2:0]        r_bitCnt;
    logic [2:0]        w_bitNext;
    logic [7:0]        r_shift;
    logic [7:0]        w_shiftNext;
    logic              w_push;
    logic              w_frameErrSet;
    logic              w_overrunSet;
    logic              w_fifoEmpty;
    logic              w_fifoFull;
    logic              r_frameErr;
    logic              r_overrun;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rxMeta    <= 1'b1;
            r_rxSync    <= 1'b1;
            r_state     <= IDLE;
            r_sampleCnt <= '0;
            r_bitCnt    <= '0;
            r_shift     <= 8'h00;
        end else begin
            r_rxMeta    <= rx;
            r_rxSync    <= r_rxMeta;
            r_state     <= w_stateNext;
            r_sampleCnt <= w_sampleNext;
            r_bitCnt    <= w_bitNext;
            r_shift     <= w_shiftNext;
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_sampleNext  = r_sampleCnt;
        w_bitNext     = r_bitCnt;
        w_shiftNext   = r_shift;
        w_push        = 1'b0;
        w_frameErrSet = 1'b0;
        case (r_state)
            IDLE: begin
                w_sampleNext = '0;
                w_bitNext    = '0;
                if (!r_rxSync) begin
                    w_stateNext = START;
                end
            end
            START: begin
                if (r_sampleCnt == HALF_LAST) begin
                    w_sampleNext = '0;
                    w_stateNext  = r_rxSync ? IDLE : DATA;
                end else begin
                    w_sampleNext = r_sampleCnt + SCNT_W'(1);
                end
            end
            DATA: begin
                if (r_sampleCnt == FULL_LAST) begin
                    w_sampleNext = '0;
                    w_shiftNext  = {r_rxSync, r_shift[7:1]};
                    w_bitNext    = r_bitCnt + 3'd1;
                    if (r_bitCnt == 3'd7) begin
                        w_stateNext = STOP;
                    end
                end else begin
                    w_sampleNext = r_sampleCnt + SCNT_W'(1);
                end
            end
            STOP: begin
                if (r_sampleCnt == FULL_LAST) begin
                    w_sampleNext = '0;
                    if (r_rxSync) begin
                        w_push      = 1'b1;
                        w_stateNext = IDLE;
                    end else begin
                        w_frameErrSet = 1'b1;
                        w_stateNext   = WAIT_HIGH;
                    end
                end else begin
                    w_sampleNext = r_sampleCnt + SCNT_W'(1);
                end
            end
            WAIT_HIGH: begin
                w_sampleNext = '0;
                w_bitNext    = '0;
                if (r_rxSync) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // A full FIFO always has a valid head, so rd_en alone means a pop frees the slot.
    assign w_overrunSet = w_push && w_fifoFull && !rd_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frameErr <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_frameErrSet) begin
                r_frameErr <= 1'b1;
            end else if (clr_err) begin
                r_frameErr <= 1'b0;
            end
            if (w_overrunSet) begin
                r_overrun <= 1'b1;
            end else if (clr_err) begin
                r_overrun <= 1'b0;
            end
        end
    end

    rx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .din   (r_shift),
        .pop   (rd_en),
        .dout  (rd_data),
        .empty (w_fifoEmpty),
        .full  (w_fifoFull)
    );

    assign rd_valid  = !w_fifoEmpty;
    assign frame_err = r_frameErr;
    assign overrun   = r_overrun;
    assign irq       = rd_valid | r_frameErr | r_overrun;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: one task per scenario, each with its own inline checks.
module tb_uart_receiver;

    localparam int CPB = 16;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       frame_err;
    logic       overrun;
    logic       irq;

    int vecCount;
    int missCount;

    uart_receiver #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .rd_en    (rd_en),
        .clr_err  (clr_err),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .frame_err(frame_err),
        .overrun  (overrun),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Start bit falls 1 time unit after a rising edge; each bit lasts CPB clocks.
    task automatic send_frame(input logic [7:0] data, input logic stopBit, input int stopClks);
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = data[i];
            repeat (CPB) @(posedge clk);
        end
        #1 rx = stopBit;
        repeat (stopClks) @(posedge clk);
        #1 rx = 1'b1;
    endtask

    task automatic pop_one();
        @(negedge clk) rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk) clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vecCount++;
        if (rd_data !== 8'h00) begin missCount++; $display("[TB] FAIL reset_rd_data: got %h expected 00", rd_data); end
        vecCount++;
        if (rd_valid !== 1'b0) begin missCount++; $display("[TB] FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        vecCount++;
        if (frame_err !== 1'b0) begin missCount++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); end
        vecCount++;
        if (overrun !== 1'b0) begin missCount++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
        vecCount++;
        if (irq !== 1'b0) begin missCount++; $display("[TB] FAIL reset_irq: got %b expected 0", irq); end
        @(negedge clk) reset = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_basic();
        bit found;
        found = 1'b0;
        fork
            send_frame(8'h55, 1'b1, CPB);
            begin
                int c;
                c = 0;
                @(negedge rx);
                while (c < 154 && !found) begin
                    @(posedge clk);
                    #1;
                    c++;
                    if (rd_valid === 1'b1) found = 1'b1;
                end
            end
        join
        vecCount++;
        if (found !== 1'b1) begin missCount++; $display("[TB] FAIL basic_latency: got no rd_valid expected rd_valid within 154 clks"); end
        vecCount++;
        if (rd_data !== 8'h55) begin missCount++; $display("[TB] FAIL basic_data: got %h expected 55", rd_data); end
        vecCount++;
        if (irq !== 1'b1) begin missCount++; $display("[TB] FAIL basic_irq: got %b expected 1", irq); end
        pop_one();
        vecCount++;
        if (rd_valid !== 1'b0) begin missCount++; $display("[TB] FAIL basic_pop_valid: got %b expected 0", rd_valid); end
        vecCount++;
        if (irq !== 1'b0) begin missCount++; $display("[TB] FAIL basic_pop_irq: got %b expected 0", irq); end
    endtask

    task automatic test_glitch();
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        vecCount++;
        if (rd_valid !== 1'b0) begin missCount++; $display("[TB] FAIL glitch_valid: got %b expected 0", rd_valid); end
        vecCount++;
        if (frame_err !== 1'b0) begin missCount++; $display("[TB] FAIL glitch_frame_err: got %b expected 0", frame_err); end
        send_frame(8'h0F, 1'b1, CPB);
        repeat (4) @(posedge clk);
        #1;
        vecCount++;
        if (rd_valid !== 1'b1) begin missCount++; $display("[TB] FAIL glitch_next_valid: got %b expected 1", rd_valid); end
        vecCount++;
        if (rd_data !== 8'h0F) begin missCount++; $display("[TB] FAIL glitch_next_data: got %h expected 0f", rd_data); end
        pop_one();
    endtask

    task automatic test_frame_error();
        send_frame(8'hA3, 1'b0, 40);
        repeat (10) @(posedge clk);
        #1;
        vecCount++;
        if (frame_err !== 1'b1) begin missCount++; $display("[TB] FAIL ferr_set: got %b expected 1", frame_err); end
        vecCount++;
        if (rd_valid !== 1'b0) begin missCount++; $display("[TB] FAIL ferr_no_push: got %b expected 0", rd_valid); end
        vecCount++;
        if (irq !== 1'b1) begin missCount++; $display("[TB] FAIL ferr_irq: got %b expected 1", irq); end
        repeat (40) @(posedge clk);
        #1;
        vecCount++;
        if (rd_valid !== 1'b0) begin missCount++; $display("[TB] FAIL ferr_spurious: got %b expected 0", rd_valid); end
        pulse_clr();
        vecCount++;
        if (frame_err !== 1'b0) begin missCount++; $display("[TB] FAIL ferr_clear: got %b expected 0", frame_err); end
        vecCount++;
        if (irq !== 1'b0) begin missCount++; $display("[TB] FAIL ferr_clear_irq: got %b expected 0", irq); end
    endtask

    task automatic test_overrun();
        for (int b = 1; b <= 4; b++) send_frame(8'(b), 1'b1, CPB);
        // clr_err lands on the dropping edge of 0x05, so the set must win.
        fork
            send_frame(8'h05, 1'b1, CPB);
            begin
                @(negedge rx);
                repeat (153) @(posedge clk);
                #1 clr_err = 1'b1;
                @(posedge clk);
                #1 clr_err = 1'b0;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        vecCount++;
        if (overrun !== 1'b1) begin missCount++; $display("[TB] FAIL ovr_set: got %b expected 1", overrun); end
        vecCount++;
        if (irq !== 1'b1) begin missCount++; $display("[TB] FAIL ovr_irq: got %b expected 1", irq); end
        for (int b = 1; b <= 4; b++) begin
            vecCount++;
            if (rd_data !== 8'(b)) begin missCount++; $display("[TB] FAIL ovr_pop_data: got %h expected %h", rd_data, 8'(b)); end
            pop_one();
        end
        vecCount++;
        if (rd_valid !== 1'b0) begin missCount++; $display("[TB] FAIL ovr_drained: got %b expected 0", rd_valid); end
        pulse_clr();
        vecCount++;
        if (overrun !== 1'b0) begin missCount++; $display("[TB] FAIL ovr_clear: got %b expected 0", overrun); end
    endtask

    task automatic test_full_pop();
        logic [7:0] expq [4];
        expq[0] = 8'h02;
        expq[1] = 8'h03;
        expq[2] = 8'h04;
        expq[3] = 8'h06;
        for (int b = 1; b <= 4; b++) send_frame(8'(b), 1'b1, CPB);
        fork
            send_frame(8'h06, 1'b1, CPB);
            begin
                @(negedge rx);
                repeat (153) @(posedge clk);
                #1 rd_en = 1'b1;
                @(posedge clk);
                #1 rd_en = 1'b0;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        vecCount++;
        if (overrun !== 1'b0) begin missCount++; $display("[TB] FAIL full_pop_overrun: got %b expected 0", overrun); end
        for (int i = 0; i < 4; i++) begin
            vecCount++;
            if (rd_valid !== 1'b1 || rd_data !== expq[i]) begin
                missCount++;
                $display("[TB] FAIL full_pop_order: got valid=%b data=%h expected valid=1 data=%h", rd_valid, rd_data, expq[i]);
            end
            pop_one();
        end
        vecCount++;
        if (rd_valid !== 1'b0) begin missCount++; $display("[TB] FAIL full_pop_drained: got %b expected 0", rd_valid); end
    endtask

    task automatic test_reset_abort();
        logic [7:0] aborted;
        aborted = 8'h3C;
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            #1 rx = aborted[i];
            repeat (CPB) @(posedge clk);
        end
        #1 rx = aborted[4];
        repeat (CPB / 2) @(posedge clk);
        #1 reset = 1'b1;
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        vecCount++;
        if (rd_valid !== 1'b0) begin missCount++; $display("[TB] FAIL abort_no_push: got %b expected 0", rd_valid); end
        send_frame(8'h7E, 1'b1, CPB);
        repeat (4) @(posedge clk);
        #1;
        vecCount++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h7E) begin
            missCount++;
            $display("[TB] FAIL abort_next_byte: got valid=%b data=%h expected valid=1 data=7e", rd_valid, rd_data);
        end
        vecCount++;
        if (frame_err !== 1'b0 || overrun !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL abort_flags: got ferr=%b ovr=%b expected 0 0", frame_err, overrun);
        end
        pop_one();
        vecCount++;
        if (rd_valid !== 1'b0 || irq !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL abort_only_one: got valid=%b irq=%b expected 0 0", rd_valid, irq);
        end
    endtask

    initial begin
        vecCount  = 0;
        missCount = 0;
        reset     = 1'b1;
        rx        = 1'b1;
        rd_en     = 1'b0;
        clr_err   = 1'b0;
        test_reset();
        test_basic();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_full_pop();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the clock port SHALL be named clk and the reset port reset.
REQ-002 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit, even, minimum 4.
REQ-003 Parameter FIFO_DEPTH, default 4: receive FIFO entries, a power of two, minimum 2.
REQ-004 clk  in  1  system clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 rx  in  1  asynchronous serial line, 8N1, LSB first, idle high.
REQ-007 rd_en  in  1  pop request for the FIFO head.
REQ-008 clr_err  in  1  clears the sticky error flags.
REQ-009 rd_data  out  8  FIFO head byte (show-ahead).
REQ-010 rd_valid  out  1  FIFO not empty.
REQ-011 frame_err  out  1  sticky flag: stop bit sampled low.
REQ-012 overrun  out  1  sticky flag: byte dropped because the FIFO was full.
REQ-013 irq  out  1  level interrupt: rd_valid OR frame_err OR overrun.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer, giving rx_s; both flops reset to 1.
REQ-015 FSM states SHALL be IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-016 IDLE: bit counter and sample counter are held at 0; rx_s==0 SHALL cause a transition to START.
REQ-017 START: after CLKS_PER_BIT/2 cycles, rx_s is sampled; 0 SHALL go to DATA; 1 (glitch) SHALL return to IDLE with no side effect.
REQ-018 DATA: every CLKS_PER_BIT cycles, rx_s SHALL be shifted into the shift register LSB first; after the 8th sample the FSM goes to STOP.
REQ-019 STOP: CLKS_PER_BIT cycles later, rx_s is sampled; 1 SHALL push the byte and go to IDLE; 0 SHALL discard the byte, set frame_err and go to WAIT_HIGH.
REQ-020 WAIT_HIGH SHALL stay until rx_s==1, then go to IDLE; this prevents a line break from being decoded as frames.
REQ-021 A pushed byte SHALL appear on rd_data with rd_valid=1 on the cycle after the stop-sample edge when the FIFO was previously empty.
REQ-022 rd_en with rd_valid=1 SHALL pop the head on that edge; rd_en with rd_valid=0 SHALL be ignored.
REQ-023 A push to a full FIFO with no simultaneous pop SHALL drop the new byte, leave the contents unchanged and set overrun.
REQ-024 A push and a pop on the same edge when full SHALL both take effect: count is unchanged and overrun is not set.
REQ-025 A push and a pop on the same edge when count==1 SHALL leave the new byte at the head with rd_valid held at 1.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the occupancy count ranges 0..FIFO_DEPTH and is one bit wider than the pointers.
REQ-027 clr_err SHALL clear frame_err and overrun on the next edge; if an error event occurs on the same edge, the set SHALL take priority.
REQ-028 Byte ordering SHALL be strictly FIFO; no byte is duplicated or reordered.

Reset
REQ-029 On reset: FSM=IDLE, counters=0, shift register=0x00, FIFO empty, rd_data=0x00, rd_valid=0, frame_err=0, overrun=0, irq=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame without a push.
REQ-031 After reset release, the receiver SHALL start only on a fresh high-to-low edge of rx_s.

Structure
REQ-032 A shared package uart_pkg SHALL hold the FSM state enum and the default values of CLKS_PER_BIT and FIFO_DEPTH.
REQ-033 The FIFO SHALL be a separate sub-module rx_fifo with ports push, din, pop, dout, empty and full.
REQ-034 The FSM, synchronizer, counters and error flags SHALL reside in uart_receiver.

Verification (CLKS_PER_BIT=16, 10 ns clk)
REQ-035 Send 0x55, idle gaps 160 ns -> rd_data=0x55, rd_valid=1 within 154 clks of the start edge; irq=1; one rd_en -> rd_valid=0, irq=0.
REQ-036 rx low for 4 clks, then high -> no push; FSM back in IDLE; rd_valid=0.
REQ-037 Send 0xA3 with the stop bit driven 0, rx held low for 40 clks, then high -> frame_err=1, FIFO empty, no spurious byte; clr_err pulse -> frame_err=0.
REQ-038 Send 0x01..0x05 back-to-back with no reads (FIFO_DEPTH=4) -> overrun=1; pops return 0x01, 0x02, 0x03, 0x04, then rd_valid=0.
REQ-039 FIFO full, rd_en asserted on the push edge of 0x06 -> overrun stays 0, count stays 4, head becomes 0x02.
REQ-040 Assert reset during bit 4 of 0x3C, release, then send 0x7E -> only 0x7E is received; all flags 0.
